iterative_shifter: RTL
======================

ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits.
REQ-002 Parameter AMT_W, default 3, SHALL set the shift-amount width, equal to clog2(WIDTH).
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate that operand, amount, dir and arith are valid.
REQ-006 in_ready  output  1  SHALL be high when a new request can be accepted.
REQ-007 operand  input  WIDTH  SHALL be the signed operand to shift.
REQ-008 amount  input  AMT_W  SHALL be the unsigned shift distance, 0..WIDTH-1.
REQ-009 dir  input  1  SHALL select direction: 0 = left, 1 = right.
REQ-010 arith  input  1  SHALL select the shift type: 0 = logical, 1 = arithmetic.
REQ-011 out_valid  output  1  SHALL indicate that result is valid.
REQ-012 out_ready  input  1  SHALL indicate that the consumer accepts result.
REQ-013 result  output  WIDTH  SHALL carry the shifted value.
REQ-014 busy  output  1  SHALL be high in the SHIFT and DONE states.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be high only in IDLE.
REQ-017 A request SHALL be accepted on a cycle where in_valid and in_ready are both high.
REQ-018 On acceptance, the block SHALL capture operand, amount, dir and arith into internal registers.
REQ-019 On acceptance, the block SHALL go to SHIFT if amount is nonzero, otherwise to DONE.
REQ-020 In SHIFT, each cycle SHALL shift the working register one bit in the captured direction and decrement the remaining count.
REQ-021 The transition SHALL be SHIFT -> DONE on the cycle the count reaches 0.
REQ-022 A right shift with arith = 1 SHALL fill with the captured MSB (sign bit); a right shift with arith = 0 SHALL fill with 0.
REQ-023 A left shift SHALL fill with 0 regardless of arith.
REQ-024 The result SHALL equal operand >>> amount, >> amount, or << amount, as selected by dir and arith.
REQ-025 out_valid SHALL be high only in DONE, and result SHALL be the working register.
REQ-026 Latency SHALL be amount+1 cycles from acceptance to out_valid; amount = 0 gives 1 cycle.
REQ-027 In DONE, result SHALL hold stable until out_valid and out_ready are both high, which SHALL return the FSM to IDLE.
REQ-028 in_valid arriving outside IDLE SHALL be ignored; requests are not queued.
REQ-029 A request SHALL NOT be accepted on the same cycle as a DONE handshake, because in_ready is low in DONE.
REQ-030 out_ready held high continuously SHALL give a throughput of one result per amount+2 cycles.

Reset
REQ-031 While reset is high at a clock edge, the FSM SHALL go to IDLE, whatever the current state.
REQ-032 Reset SHALL force in_ready = 1, out_valid = 0, busy = 0, result = 0 and count = 0.
REQ-033 Reset in the middle of SHIFT or DONE SHALL discard the transaction with no output.
REQ-034 reset SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-035 The state encoding SHALL be placed in the shared package shifter_pkg.
REQ-036 The dir and arith encodings SHALL be defined as named constants in shifter_pkg.
REQ-037 The one-bit shift step SHALL be a combinational sub-module named shift_step (inputs: value, dir, arith; output: next value).
REQ-038 Only iterative_shifter SHALL hold state.

Verification
REQ-039 Directed test: operand = -15 (11110001), amount = 3, dir = 1, arith = 0 -> result 00011110, out_valid 4 cycles after acceptance.
REQ-040 Directed test: operand = -15, amount = 3, dir = 1, arith = 1 -> 11111110; with dir = 0 -> 10001000 for both arith values.
REQ-041 Directed test: operand = -50 (11001110), amount = 3, right -> arithmetic 11111001, logical 00011001; operand = 127, left 3 -> 11111000.
REQ-042 Directed test: amount = 0, operand = 01010101 -> result 01010101, out_valid 1 cycle after acceptance.
REQ-043 Directed test: out_ready held low for 5 cycles in DONE -> result stable, in_ready low, a second in_valid ignored.
REQ-044 Directed test: reset asserted on the second SHIFT cycle -> next cycle in IDLE, out_valid 0, result 0, and a following request completes correctly.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter: FSM state encoding and the
// dir/arith control encodings.
package shifter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT      = 1'b0;
  localparam logic DIR_RIGHT     = 1'b1;
  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shift: left fills with 0, right fills with 0 or the
// current MSB depending on arith.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] next_value
);

  always_comb begin
    next_value = value;
    if (dir == DIR_RIGHT) begin
      next_value = {(arith == SHIFT_ARITH) & value[WIDTH-1], value[WIDTH-1:1]};
    end else begin
      next_value = {value[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: moves the captured operand one bit per cycle and
// presents the result with a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a request, in_ready high
// S_SHIFT | one bit per cycle, count holds the remaining distance
// S_DONE  | result valid, held until out_ready
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  input  logic             dir,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic [AMT_W-1:0] count;
  logic             dir_q;
  logic             arith_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value      (work),
    .dir        (dir_q),
    .arith      (arith_q),
    .next_value (work_next)
  );

  assign result = work;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      work      <= '0;
      count     <= '0;
      dir_q     <= DIR_LEFT;
      arith_q   <= SHIFT_LOGICAL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            work     <= operand;
            count    <= amount;
            dir_q    <= dir;
            arith_q  <= arith;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (amount != '0) begin
              state <= S_SHIFT;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          work  <= work_next;
          count <= count - AMT_W'(1);
          // The last shift lands on the same edge that enters DONE.
          if (count == AMT_W'(1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
